syn_up_counter: RTL and testbench

Parameterised synchronous up counter: the count-up complement of the team's JK-based down counter. It uses the same per-bit JK flip-flop construction. It adds a programmable modulus, a synchronous parallel load, a count enable and cascade outputs, so several instances can be chained into wider counters or used as prescalers alongside the down counter.

---
 rtl/syn_up_counter_pkg.sv | 29 ++
 rtl/syn_up_counter_if.sv | 26 ++
 rtl/syn_up_counter_jk_ff.sv | 31 +++
 rtl/syn_up_counter.sv | 110 +++++++++++
 tb/tb_syn_up_counter.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/syn_up_counter_pkg.sv
// syn_up_counter_pkg: shared limits, next-state op codes and the parameter range check.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package syn_up_counter_pkg;

    // Parameter limits shared with the down counter family.
    localparam int WIDTH_MIN   = 1;
    localparam int WIDTH_MAX   = 16;
    localparam int MODULUS_MIN = 2;

    // Decision taken by the priority logic on each edge (reset handled separately).
    typedef enum logic [2:0] {
        OP_HOLD     = 3'd0,
        OP_INC      = 3'd1,
        OP_WRAP     = 3'd2,
        OP_LOAD     = 3'd3,
        OP_LOAD_BAD = 3'd4
    } op_e;

    // True when WIDTH/MODULUS form a legal counter. Width is checked first so the
    // shift below never sees an out-of-range amount.
    function automatic bit params_ok(input int width, input int modulus);
        if (width < WIDTH_MIN || width > WIDTH_MAX) begin
            return 1'b0;
        end
        return (modulus >= MODULUS_MIN) && (modulus <= (1 << width));
    endfunction

endpackage

// File: rtl/syn_up_counter_if.sv
// syn_up_counter_if: control and status bundle of one counter stage.
// Latency: n/a (wires only). master drives en/load/d, slave returns count and flags.
// Backpressure: none; en is the only flow control and co feeds the next stage's en.
interface syn_up_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;      // count enable
    logic             load;    // synchronous parallel load
    logic [WIDTH-1:0] d;       // load value
    logic [WIDTH-1:0] q;       // current count
    logic [WIDTH-1:0] qb;      // complement of q
    logic             tc;      // q == MODULUS-1
    logic             co;      // tc & en & ~load, cascade carry
    logic             ovf;     // sticky wrap flag
    logic             ld_err;  // one-cycle pulse after an out-of-range load

    modport master (
        output en, load, d,
        input  q, qb, tc, co, ovf, ld_err
    );

    modport slave (
        input  en, load, d,
        output q, qb, tc, co, ovf, ld_err
    );
endinterface

// File: rtl/syn_up_counter_jk_ff.sv
// jk_ff: single JK flip-flop with Q-bar output; ports clk, rst (sync active-low), j, k, q, qb.
// Latency: 1 cycle from j/k to q.
// Backpressure: none.
module jk_ff (
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qb
);

    logic q_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            q_q <= 1'b0;
        end else begin
            case ({j, k})
                2'b01:   q_q <= 1'b0;
                2'b10:   q_q <= 1'b1;
                2'b11:   q_q <= ~q_q;
                default: q_q <= q_q;
            endcase
        end
    end

    assign q  = q_q;
    assign qb = ~q_q;

endmodule

// File: rtl/syn_up_counter.sv
// syn_up_counter: modulus-MODULUS up counter built from per-bit JK flops, with load, enable, cascade.
// Latency: q/qb/ovf/ld_err 1 cycle after inputs; tc/co combinational in the same cycle.
// Backpressure: none; stages chain by wiring co of one stage into en of the next.
// Ports: clk, rst (sync active-low), bus (slave: en, load, d in; q, qb, tc, co, ovf, ld_err out).
module syn_up_counter
    import syn_up_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input logic             clk,
    input logic             rst,
    syn_up_counter_if.slave bus
);

    // Illegal WIDTH/MODULUS stops elaboration; there is no runtime guard.
    if (!params_ok(WIDTH, MODULUS)) begin : g_bad_params
        $error("syn_up_counter: illegal WIDTH=%0d / MODULUS=%0d", WIDTH, MODULUS);
    end

    localparam logic [WIDTH-1:0] LAST  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
    localparam int unsigned      MOD_U = MODULUS;

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_qb;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] tgl;
    logic             ovf_q;
    logic             ovf_d;
    logic             ld_err_q;
    logic             ld_err_d;
    logic             tc;
    logic             d_ok;
    op_e              op;

    assign tc   = (cnt_q == LAST);
    assign d_ok = (32'(bus.d) < MOD_U);

    // Priority: load over count over hold (reset acts inside the flops).
    always_comb begin
        op = OP_HOLD;
        if (bus.load) begin
            op = d_ok ? OP_LOAD : OP_LOAD_BAD;
        end else if (bus.en) begin
            op = tc ? OP_WRAP : OP_INC;
        end
    end

    always_comb begin
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        ld_err_d = 1'b0;
        case (op)
            OP_LOAD: begin
                cnt_d = bus.d;
                ovf_d = 1'b0;
            end
            OP_LOAD_BAD: begin
                cnt_d    = '0;
                ovf_d    = 1'b0;
                ld_err_d = 1'b1;
            end
            OP_INC: begin
                cnt_d = cnt_q + ONE;
            end
            OP_WRAP: begin
                cnt_d = '0;
                ovf_d = 1'b1;
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    // Every state change, including load and wrap, is expressed as a toggle of
    // the bits that differ between the current and the next count.
    assign tgl = cnt_q ^ cnt_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        jk_ff u_ff (
            .clk (clk),
            .rst (rst),
            .j   (tgl[i]),
            .k   (tgl[i]),
            .q   (cnt_q[i]),
            .qb  (cnt_qb[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ovf_q    <= 1'b0;
            ld_err_q <= 1'b0;
        end else begin
            ovf_q    <= ovf_d;
            ld_err_q <= ld_err_d;
        end
    end

    assign bus.q      = cnt_q;
    assign bus.qb     = cnt_qb;
    assign bus.tc     = tc;
    // Left combinational so a downstream stage sees the carry in the same cycle.
    assign bus.co     = tc & bus.en & ~bus.load;
    assign bus.ovf    = ovf_q;
    assign bus.ld_err = ld_err_q;

endmodule

// File: tb/tb_syn_up_counter.sv
module tb_syn_up_counter;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    syn_up_counter_if #(.WIDTH(4)) bus16 ();
    syn_up_counter_if #(.WIDTH(4)) bus10 ();
    syn_up_counter_if #(.WIDTH(4)) bus_c0 ();
    syn_up_counter_if #(.WIDTH(4)) bus_c1 ();

    assign bus_c1.en = bus_c0.co;

    syn_up_counter #(.WIDTH(4), .MODULUS(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));
    syn_up_counter #(.WIDTH(4), .MODULUS(10)) dut10 (.clk(clk), .rst(rst), .bus(bus10.slave));
    syn_up_counter #(.WIDTH(4), .MODULUS(10)) dut_c0 (.clk(clk), .rst(rst), .bus(bus_c0.slave));
    syn_up_counter #(.WIDTH(4), .MODULUS(10)) dut_c1 (.clk(clk), .rst(rst), .bus(bus_c1.slave));

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0] q;
        logic       ovf;
        logic       ld_err;
    } exp_t;

    exp_t sb[$];

    // One row per cycle: inputs, expected tc/co before the edge, expected registers after it.
    typedef struct packed {
        logic       ld;
        logic       en;
        logic [3:0] d;
        logic       tc;
        logic       co;
        logic [3:0] q;
        logic       ovf;
        logic       lderr;
    } step_t;

    step_t load_steps[14] = '{
        '{1'b1, 1'b0, 4'd13, 1'b0, 1'b0, 4'd13, 1'b0, 1'b0},
        '{1'b0, 1'b1, 4'd0,  1'b0, 1'b0, 4'd14, 1'b0, 1'b0},
        '{1'b0, 1'b1, 4'd0,  1'b0, 1'b0, 4'd15, 1'b0, 1'b0},
        '{1'b0, 1'b1, 4'd0,  1'b1, 1'b1, 4'd0,  1'b1, 1'b0},
        '{1'b0, 1'b1, 4'd0,  1'b0, 1'b0, 4'd1,  1'b1, 1'b0},
        '{1'b0, 1'b1, 4'd0,  1'b0, 1'b0, 4'd2,  1'b1, 1'b0},
        '{1'b0, 1'b1, 4'd0,  1'b0, 1'b0, 4'd3,  1'b1, 1'b0},
        '{1'b1, 1'b1, 4'd12, 1'b0, 1'b0, 4'd12, 1'b0, 1'b0},
        '{1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 4'd12, 1'b0, 1'b0},
        '{1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 4'd12, 1'b0, 1'b0},
        '{1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 4'd12, 1'b0, 1'b0},
        '{1'b1, 1'b0, 4'd15, 1'b0, 1'b0, 4'd15, 1'b0, 1'b0},
        '{1'b1, 1'b1, 4'd4,  1'b1, 1'b0, 4'd4,  1'b0, 1'b0},
        '{1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 4'd4,  1'b0, 1'b0}
    };

    // Starts from dut10 at q=1, ovf=1 (left there by the decade run).
    step_t bad_steps[9] = '{
        '{1'b1, 1'b0, 4'd9,  1'b0, 1'b0, 4'd9, 1'b0, 1'b0},
        '{1'b0, 1'b1, 4'd0,  1'b1, 1'b1, 4'd0, 1'b1, 1'b0},
        '{1'b1, 1'b0, 4'd10, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1},
        '{1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 4'd0, 1'b0, 1'b0},
        '{1'b0, 1'b1, 4'd0,  1'b0, 1'b0, 4'd1, 1'b0, 1'b0},
        '{1'b1, 1'b1, 4'd11, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1},
        '{1'b1, 1'b0, 4'd15, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1},
        '{1'b1, 1'b0, 4'd3,  1'b0, 1'b0, 4'd3, 1'b0, 1'b0},
        '{1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 4'd3, 1'b0, 1'b0}
    };

    task automatic idle_all();
        bus16.en = 1'b0;  bus16.load = 1'b0;  bus16.d = 4'd0;
        bus10.en = 1'b0;  bus10.load = 1'b0;  bus10.d = 4'd0;
        bus_c0.en = 1'b0; bus_c0.load = 1'b0; bus_c0.d = 4'd0;
        bus_c1.load = 1'b0; bus_c1.d = 4'd0;
    endtask

    task automatic pulse_reset();
        idle_all();
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b0;
        bus16.en = 1'b1;  bus16.load = 1'b1;  bus16.d = 4'd5;
        bus10.en = 1'b1;  bus10.load = 1'b1;  bus10.d = 4'd5;
        bus_c0.en = 1'b1; bus_c0.load = 1'b1; bus_c0.d = 4'd5;
        bus_c1.load = 1'b1; bus_c1.d = 4'd5;
        for (int i = 0; i < 2; i++) begin
            sb.push_back('{q: 4'd0, ovf: 1'b0, ld_err: 1'b0});
            @(posedge clk); #1;
            e = sb.pop_front();
            n_checks++; if (bus16.q !== e.q) begin n_fail++; $display("FAIL reset_q cyc%0d got %h want %h", i, bus16.q, e.q); end
            n_checks++; if (bus16.qb !== ~e.q) begin n_fail++; $display("FAIL reset_qb cyc%0d got %h want %h", i, bus16.qb, ~e.q); end
            n_checks++; if (bus16.ovf !== e.ovf) begin n_fail++; $display("FAIL reset_ovf cyc%0d got %b want %b", i, bus16.ovf, e.ovf); end
            n_checks++; if (bus16.ld_err !== e.ld_err) begin n_fail++; $display("FAIL reset_ld_err cyc%0d got %b want %b", i, bus16.ld_err, e.ld_err); end
            n_checks++; if (bus16.tc !== 1'b0) begin n_fail++; $display("FAIL reset_tc cyc%0d got %b want 0", i, bus16.tc); end
            n_checks++; if (bus16.co !== 1'b0) begin n_fail++; $display("FAIL reset_co cyc%0d got %b want 0", i, bus16.co); end
            n_checks++; if (bus10.q !== e.q) begin n_fail++; $display("FAIL reset_q10 cyc%0d got %h want %h", i, bus10.q, e.q); end
            n_checks++; if (bus_c1.q !== e.q) begin n_fail++; $display("FAIL reset_qc1 cyc%0d got %h want %h", i, bus_c1.q, e.q); end
        end
        idle_all();
        rst = 1'b1;
    endtask

    task automatic test_free_count();
        exp_t e;
        int   cur;
        pulse_reset();
        for (int i = 0; i < 17; i++) begin
            bus16.en = 1'b1;
            #1;
            cur = i % 16;
            n_checks++; if (bus16.tc !== (cur == 15)) begin n_fail++; $display("FAIL free_tc q=%0d got %b want %b", cur, bus16.tc, cur == 15); end
            n_checks++; if (bus16.co !== (cur == 15)) begin n_fail++; $display("FAIL free_co q=%0d got %b want %b", cur, bus16.co, cur == 15); end
            sb.push_back('{q: 4'((i + 1) % 16), ovf: (i >= 15), ld_err: 1'b0});
            @(posedge clk); #1;
            e = sb.pop_front();
            n_checks++; if (bus16.q !== e.q) begin n_fail++; $display("FAIL free_q step%0d got %h want %h", i, bus16.q, e.q); end
            n_checks++; if (bus16.qb !== ~e.q) begin n_fail++; $display("FAIL free_qb step%0d got %h want %h", i, bus16.qb, ~e.q); end
            n_checks++; if (bus16.ovf !== e.ovf) begin n_fail++; $display("FAIL free_ovf step%0d got %b want %b", i, bus16.ovf, e.ovf); end
            n_checks++; if (bus16.ld_err !== e.ld_err) begin n_fail++; $display("FAIL free_ld_err step%0d got %b want %b", i, bus16.ld_err, e.ld_err); end
        end
        bus16.en = 1'b0;
    endtask

    task automatic test_decade();
        exp_t e;
        int   cur;
        pulse_reset();
        for (int i = 0; i < 11; i++) begin
            bus10.en = 1'b1;
            #1;
            cur = i % 10;
            n_checks++; if (bus10.tc !== (cur == 9)) begin n_fail++; $display("FAIL dec_tc q=%0d got %b want %b", cur, bus10.tc, cur == 9); end
            n_checks++; if (bus10.co !== (cur == 9)) begin n_fail++; $display("FAIL dec_co q=%0d got %b want %b", cur, bus10.co, cur == 9); end
            sb.push_back('{q: 4'((i + 1) % 10), ovf: (i >= 9), ld_err: 1'b0});
            @(posedge clk); #1;
            e = sb.pop_front();
            n_checks++; if (bus10.q !== e.q) begin n_fail++; $display("FAIL dec_q step%0d got %h want %h", i, bus10.q, e.q); end
            n_checks++; if (bus10.ovf !== e.ovf) begin n_fail++; $display("FAIL dec_ovf step%0d got %b want %b", i, bus10.ovf, e.ovf); end
        end
        bus10.en = 1'b0;
    endtask

    task automatic test_load_hold();
        exp_t  e;
        step_t s;
        for (int i = 0; i < 14; i++) begin
            s = load_steps[i];
            bus16.load = s.ld; bus16.en = s.en; bus16.d = s.d;
            #1;
            n_checks++; if (bus16.tc !== s.tc) begin n_fail++; $display("FAIL ld_tc step%0d got %b want %b", i, bus16.tc, s.tc); end
            n_checks++; if (bus16.co !== s.co) begin n_fail++; $display("FAIL ld_co step%0d got %b want %b", i, bus16.co, s.co); end
            sb.push_back('{q: s.q, ovf: s.ovf, ld_err: s.lderr});
            @(posedge clk); #1;
            e = sb.pop_front();
            n_checks++; if (bus16.q !== e.q) begin n_fail++; $display("FAIL ld_q step%0d got %h want %h", i, bus16.q, e.q); end
            n_checks++; if (bus16.qb !== ~e.q) begin n_fail++; $display("FAIL ld_qb step%0d got %h want %h", i, bus16.qb, ~e.q); end
            n_checks++; if (bus16.ovf !== e.ovf) begin n_fail++; $display("FAIL ld_ovf step%0d got %b want %b", i, bus16.ovf, e.ovf); end
            n_checks++; if (bus16.ld_err !== e.ld_err) begin n_fail++; $display("FAIL ld_ld_err step%0d got %b want %b", i, bus16.ld_err, e.ld_err); end
        end
        bus16.load = 1'b0; bus16.en = 1'b0;
    endtask

    task automatic test_invalid_load();
        exp_t  e;
        step_t s;
        for (int i = 0; i < 9; i++) begin
            s = bad_steps[i];
            bus10.load = s.ld; bus10.en = s.en; bus10.d = s.d;
            #1;
            n_checks++; if (bus10.tc !== s.tc) begin n_fail++; $display("FAIL bad_tc step%0d got %b want %b", i, bus10.tc, s.tc); end
            n_checks++; if (bus10.co !== s.co) begin n_fail++; $display("FAIL bad_co step%0d got %b want %b", i, bus10.co, s.co); end
            sb.push_back('{q: s.q, ovf: s.ovf, ld_err: s.lderr});
            @(posedge clk); #1;
            e = sb.pop_front();
            n_checks++; if (bus10.q !== e.q) begin n_fail++; $display("FAIL bad_q step%0d got %h want %h", i, bus10.q, e.q); end
            n_checks++; if (bus10.ovf !== e.ovf) begin n_fail++; $display("FAIL bad_ovf step%0d got %b want %b", i, bus10.ovf, e.ovf); end
            n_checks++; if (bus10.ld_err !== e.ld_err) begin n_fail++; $display("FAIL bad_ld_err step%0d got %b want %b", i, bus10.ld_err, e.ld_err); end
        end
        bus10.load = 1'b0; bus10.en = 1'b0;
    endtask

    task automatic test_cascade();
        exp_t e0;
        exp_t e1;
        pulse_reset();
        for (int i = 1; i <= 100; i++) begin
            bus_c0.en = 1'b1;
            #1;
            n_checks++; if (bus_c0.co !== ((i - 1) % 10 == 9)) begin n_fail++; $display("FAIL cas_co0 step%0d got %b want %b", i, bus_c0.co, (i - 1) % 10 == 9); end
            sb.push_back('{q: 4'(i % 10), ovf: (i >= 10), ld_err: 1'b0});
            sb.push_back('{q: 4'((i / 10) % 10), ovf: (i >= 100), ld_err: 1'b0});
            @(posedge clk); #1;
            e0 = sb.pop_front();
            e1 = sb.pop_front();
            n_checks++; if (bus_c0.q !== e0.q) begin n_fail++; $display("FAIL cas_q0 step%0d got %h want %h", i, bus_c0.q, e0.q); end
            n_checks++; if (bus_c1.q !== e1.q) begin n_fail++; $display("FAIL cas_q1 step%0d got %h want %h", i, bus_c1.q, e1.q); end
            n_checks++; if (bus_c0.ovf !== e0.ovf) begin n_fail++; $display("FAIL cas_ovf0 step%0d got %b want %b", i, bus_c0.ovf, e0.ovf); end
            n_checks++; if (bus_c1.ovf !== e1.ovf) begin n_fail++; $display("FAIL cas_ovf1 step%0d got %b want %b", i, bus_c1.ovf, e1.ovf); end
        end
        bus_c0.en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_all();
        rst = 1'b0;
        test_reset();
        test_free_count();
        test_decade();
        test_load_hold();
        test_invalid_load();
        test_cascade();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
